// File: rtl/prog_rom_pkg.sv
// prog_rom shared types: FSM states, legal read latencies,
// and the address range check used by load and read paths.
package prog_rom_pkg;

  typedef enum logic {CLEAR, RUN} prog_rom_state_t;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

  function automatic logic in_range(
    input logic [31:0] addr,
    input int unsigned depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/prog_rom_rd_pipe.sv
// Per-port read output staging: one or two register stages
// for data, valid and err; data/err hold when no read completes.
module prog_rom_rd_pipe
  import prog_rom_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         i_acc,
  input  logic [W-1:0] i_data,
  input  logic         i_err,
  output logic [W-1:0] o_q,
  output logic         o_valid,
  output logic         o_err
);

  logic         r_v1;
  logic [W-1:0] r_d1;
  logic         r_e1;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_e1 <= 1'b0;
    end else begin
      r_v1 <= i_acc;
      if (i_acc) begin
        r_d1 <= i_data;
        r_e1 <= i_err;
      end
    end
  end

  if (LAT == RD_LAT_2) begin : g_lat2
    logic         r_v2;
    logic [W-1:0] r_d2;
    logic         r_e2;

    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
        r_e2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_d2 <= r_d1;
          r_e2 <= r_e1;
        end
      end
    end

    assign o_q     = r_d2;
    assign o_valid = r_v2;
    assign o_err   = r_e2;
  end else begin : g_lat1
    assign o_q     = r_d1;
    assign o_valid = r_v1;
    assign o_err   = r_e1;
  end

endmodule

// File: rtl/prog_rom.sv
// Loadable multi-port program memory with clear sweep,
// valid/ready load port and 1- or 2-cycle read latency.
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int INSTR_WIDTH    = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_PORTS       = 2,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                  clock,
  input  logic                                  rst,
  input  logic [RD_PORTS-1:0]                   rd_valid,
  input  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0]   rd_address,
  output logic [RD_PORTS-1:0][INSTR_WIDTH-1:0]  rd_q,
  output logic [RD_PORTS-1:0]                   rd_q_valid,
  output logic [RD_PORTS-1:0]                   rd_err,
  input  logic                                  ld_valid,
  output logic                                  ld_ready,
  input  logic [ADDR_WIDTH-1:0]                 ld_address,
  input  logic [INSTR_WIDTH-1:0]                ld_data,
  input  logic                                  clr,
  output logic                                  mem_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam prog_rom_state_t RST_STATE =
    (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  if (RD_LATENCY != RD_LAT_1 && RD_LATENCY != RD_LAT_2) begin : g_bad_lat
    $error("prog_rom: RD_LATENCY must be 1 or 2");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_aw
    $error("prog_rom: ADDR_WIDTH too small for DEPTH");
  end

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

  prog_rom_state_t  r_state;
  prog_rom_state_t  w_state_nxt;
  logic [IDX_W-1:0] r_sweep_cnt;
  logic [IDX_W-1:0] w_sweep_nxt;
  logic             r_run;
  logic             w_clear_we;
  logic             w_ld_we;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= RST_STATE;
      r_sweep_cnt <= '0;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
      r_run       <= (w_state_nxt == RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_cnt;
    w_clear_we  = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_clear_we = 1'b1;
        if (r_sweep_cnt == LAST) begin
          w_state_nxt = RUN;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr) w_state_nxt = CLEAR;
      end
    endcase
  end

  // out-of-range loads complete the handshake but never write
  assign w_ld_we = ld_valid & r_run
                 & in_range(32'(ld_address), DEPTH);

  always_ff @(posedge clock) begin
    if (w_clear_we) begin
      r_mem[r_sweep_cnt] <= '0;
    end else if (w_ld_we) begin
      r_mem[ld_address[IDX_W-1:0]] <= ld_data;
    end
  end

  assign mem_ready = r_run;
  assign ld_ready  = r_run;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic                   w_acc;
    logic                   w_err;
    logic [INSTR_WIDTH-1:0] w_data;

    assign w_acc  = rd_valid[p] & r_run;
    assign w_err  = !in_range(32'(rd_address[p]), DEPTH);
    assign w_data = w_err ? '0
                  : r_mem[rd_address[p][IDX_W-1:0]];

    prog_rom_rd_pipe #(
      .W   (INSTR_WIDTH),
      .LAT (RD_LATENCY)
    ) u_pipe (
      .clock   (clock),
      .rst     (rst),
      .i_acc   (w_acc),
      .i_data  (w_data),
      .i_err   (w_err),
      .o_q     (rd_q[p]),
      .o_valid (rd_q_valid[p]),
      .o_err   (rd_err[p])
    );
  end

endmodule

// File: tb/tb_prog_rom.sv
// Scoreboard bench for prog_rom: latency-1 and latency-2 instances
// share stimulus; a word-array model predicts every read response.
module tb_prog_rom;

  localparam int W     = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NP    = 2;

  logic                  clock = 1'b0;
  logic                  rst   = 1'b0;
  logic [NP-1:0]         rd_valid;
  logic [NP-1:0][AW-1:0] rd_address;
  logic                  ld_valid;
  logic [AW-1:0]         ld_address;
  logic [W-1:0]          ld_data;
  logic                  clr;

  logic [NP-1:0][W-1:0]  rq  [2];
  logic [NP-1:0]         rv  [2];
  logic [NP-1:0]         re  [2];
  logic                  ldr [2];
  logic                  mr  [2];

  always #5 clock = ~clock;

  prog_rom #(
    .INSTR_WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .RD_PORTS(NP), .RD_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_lat1 (
    .clock(clock), .rst(rst),
    .rd_valid(rd_valid), .rd_address(rd_address),
    .rd_q(rq[0]), .rd_q_valid(rv[0]), .rd_err(re[0]),
    .ld_valid(ld_valid), .ld_ready(ldr[0]),
    .ld_address(ld_address), .ld_data(ld_data),
    .clr(clr), .mem_ready(mr[0])
  );

  prog_rom #(
    .INSTR_WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .RD_PORTS(NP), .RD_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_lat2 (
    .clock(clock), .rst(rst),
    .rd_valid(rd_valid), .rd_address(rd_address),
    .rd_q(rq[1]), .rd_q_valid(rv[1]), .rd_err(re[1]),
    .ld_valid(ld_valid), .ld_ready(ldr[1]),
    .ld_address(ld_address), .ld_data(ld_data),
    .clr(clr), .mem_ready(mr[1])
  );

  typedef struct {
    logic [W-1:0] d;
    logic         e;
    int           due;
  } exp_t;

  exp_t         sb [2][NP][$];
  logic [W-1:0] last_q [2][NP];
  logic [W-1:0] m_mem [DEPTH];
  bit           m_ready;
  int           m_left;
  int           cyc;
  int           n_cmp;
  int           n_bad;
  exp_t         mon_e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents read data.
  always @(posedge clock) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        if (rv[d][p]) begin
          if (sb[d][p].size() == 0) begin
            chk($sformatf("extra_valid_d%0d_p%0d", d, p), rv[d][p], 0);
          end else begin
            mon_e = sb[d][p].pop_front();
            chk($sformatf("rd_q_d%0d_p%0d", d, p), rq[d][p], mon_e.d);
            chk($sformatf("rd_err_d%0d_p%0d", d, p), re[d][p], mon_e.e);
            chk($sformatf("latency_d%0d_p%0d", d, p), cyc, mon_e.due);
            last_q[d][p] = mon_e.d;
          end
        end else begin
          chk($sformatf("hold_d%0d_p%0d", d, p), rq[d][p], last_q[d][p]);
          if (sb[d][p].size() > 0 && sb[d][p][0].due <= cyc) begin
            void'(sb[d][p].pop_front());
            chk($sformatf("missing_d%0d_p%0d", d, p), rv[d][p], 1);
          end
        end
      end
    end
  end

  // Reference behaviour at one rising edge, from pre-edge state.
  task automatic model_edge();
    exp_t e;
    int   a;
    cyc++;
    if (rst) return;
    if (m_ready) begin
      for (int p = 0; p < NP; p++) begin
        if (rd_valid[p]) begin
          a   = int'(rd_address[p]);
          e.e = (a >= DEPTH);
          e.d = e.e ? '0 : m_mem[a];
          for (int d = 0; d < 2; d++) begin
            e.due = cyc + d;
            sb[d][p].push_back(e);
          end
        end
      end
      if (ld_valid && int'(ld_address) < DEPTH)
        m_mem[int'(ld_address)] = ld_data;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_ready = 1;
    end else if (m_ready && clr) begin
      m_ready = 0;
      m_left  = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mem_ready_d%0d", d), mr[d], m_ready);
      chk($sformatf("ld_ready_d%0d", d), ldr[d], m_ready);
    end
    @(negedge clock);
  endtask

  task automatic idle();
    rd_valid = '0;
    ld_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    rd_valid[p]   = 1'b1;
    rd_address[p] = AW'(a);
  endtask

  task automatic ld(input int a, input logic [W-1:0] v);
    ld_valid   = 1'b1;
    ld_address = AW'(a);
    ld_data    = v;
  endtask

  task automatic do_rst(input int hold);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        sb[d][p].delete();
        last_q[d][p] = '0;
      end
    end
    m_ready = 0;
    m_left  = DEPTH;
    foreach (m_mem[i]) m_mem[i] = '0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rd_q_d%0d", d), rq[d], '0);
      chk($sformatf("rst_rd_q_valid_d%0d", d), rv[d], '0);
      chk($sformatf("rst_rd_err_d%0d", d), re[d], '0);
      chk($sformatf("rst_mem_ready_d%0d", d), mr[d], 0);
      chk($sformatf("rst_ld_ready_d%0d", d), ldr[d], 0);
    end
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0;
    rd_address = '0; ld_address = '0; ld_data = '0;
    idle();
    #2;
    do_rst(2);
    repeat (DEPTH) tick();
    rd(0, DEPTH - 1); tick(); idle(); repeat (2) tick();

    ld(3, 32'hDEAD_BEEF); tick(); idle();
    rd(0, 3); tick(); idle(); repeat (3) tick();

    ld(5, 32'h1111); tick();
    ld(5, 32'h2222); rd(0, 5); tick(); idle();
    rd(0, 5); rd(1, 5); tick(); idle(); tick();

    ld(7, 32'hCAFE_F00D); tick(); idle();
    rd(0, 7); rd(1, 13); tick(); idle();
    ld(13, 32'h1234_5678); tick(); idle();
    for (int a = 0; a < DEPTH; a++) begin
      rd(0, a); rd(1, DEPTH - 1 - a); tick();
    end
    idle(); repeat (2) tick();

    clr = 1'b1; ld(2, 32'hABCD_0123); rd(0, 3); rd(1, 7); tick();
    clr = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, $urandom_range(0, DEPTH - 1)); rd(1, i); tick();
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      rd(0, a); rd(1, a); tick();
    end
    idle(); tick();

    clr = 1'b1; tick(); clr = 1'b0;
    repeat (8) tick();
    do_rst(1);
    repeat (DEPTH + 1) tick();

    ld(4, 32'h5A5A_A5A5); tick(); idle();
    rd(0, 4); rd(1, 14); tick(); idle();
    do_rst(2);
    repeat (DEPTH + 1) tick();

    repeat (500) begin
      rd_valid   = NP'($urandom);
      for (int p = 0; p < NP; p++) rd_address[p] = AW'($urandom_range(0, 15));
      ld_valid   = 1'($urandom);
      ld_address = AW'($urandom_range(0, 15));
      ld_data    = $urandom;
      clr        = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    repeat (4) tick();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++)
        chk($sformatf("drain_d%0d_p%0d", d, p), sb[d][p].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
